// File: rtl/dmem_ctrl.sv
// dmem_ctrl: clocked byte-addressed MEM-stage data memory, one access at a time, LATENCY-cycle access.
// Optional build macro: DMEM_MISALIGN_CHECK_EN (misaligned halfword/word accesses fault).
module dmem_ctrl #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned AW1   = ADDR_W + 1;

  // DONE is transient: the access executes on the edge that would enter it.
  typedef enum logic {S_IDLE, S_WAIT} state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } op_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d, req_op, exe_op;
  logic             exec;

  logic [31:0]      rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [7:0]       mem_q [DEPTH_BYTES];

  logic [1:0]       n_m1;
  logic [AW1-1:0]   last_addr;
  logic             fault;
  logic [IDX_W-1:0] idx [4];
  logic [7:0]       rb [4];
  logic [3:0]       wr_en;
  logic [31:0]      ld_data;

  assign req_op = '{we: we_i, size: size_i, uns: unsigned_i, addr: addr_i, wdata: wdata_i};

  // Next-state: accept in IDLE, count down in WAIT, flag the executing cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    exec    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          op_d  = req_op;
          cnt_d = CNT_W'(LATENCY - 1);
          if (LATENCY > 1) state_d = S_WAIT;
          else             exec    = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          exec    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // With LATENCY == 1 the access executes straight from the request inputs.
    exe_op = (state_q == S_IDLE) ? req_op : op_q;
  end

  // Access decode: size, range/alignment fault, byte lanes.
  always_comb begin
    unique case (exe_op.size)
      2'b00:   n_m1 = 2'd0;
      2'b01:   n_m1 = 2'd1;
      default: n_m1 = 2'd3;
    endcase
    last_addr = {1'b0, exe_op.addr} + AW1'(n_m1);
    fault     = (last_addr >= AW1'(DEPTH_BYTES));
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((exe_op.size == 2'b01 && exe_op.addr[0]) ||
        (exe_op.size[1] && exe_op.addr[1:0] != 2'b00))
      fault = 1'b1;
`endif
    for (int k = 0; k < 4; k++) begin
      idx[k]   = exe_op.addr[IDX_W-1:0] + IDX_W'(k);
      rb[k]    = mem_q[idx[k]];
      wr_en[k] = exec && exe_op.we && !fault && rst_i && (2'(k) <= n_m1);
    end
    unique case (exe_op.size)
      2'b00:   ld_data = {{24{!exe_op.uns && rb[0][7]}}, rb[0]};
      2'b01:   ld_data = {{16{!exe_op.uns && rb[1][7]}}, rb[1], rb[0]};
      default: ld_data = {rb[3], rb[2], rb[1], rb[0]};
    endcase
  end

  // Registered completion outputs; rdata holds between accesses.
  always_comb begin
    valid_d = exec;
    err_d   = exec && fault;
    rdata_d = rdata_q;
    if (exec) rdata_d = (exe_op.we || fault) ? 32'd0 : ld_data;
    busy_d  = (state_d == S_WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Storage array is not reset; writes are gated off during reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) mem_q[idx[k]] <= exe_op.wdata[8*k +: 8];
    end
  end

  assign rdata_o = rdata_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized self-checking bench for dmem_ctrl against a byte-array reference model.
// Instance A runs LATENCY=2 traffic; instance B (LATENCY=3) covers reset abort of an in-flight store.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 3;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, req_a, req_b;
  logic        we, uns;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        valid_a, busy_a, err_a;
  logic        valid_b, busy_b, err_b;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mdl [DEPTH];
  logic [31:0] last_rd = 32'd0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT_A), .ADDR_W(32)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we), .size_i(sz),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata_a), .valid_o(valid_a), .busy_o(busy_a), .err_o(err_a)
  );

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT_B), .ADDR_W(32)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we), .size_i(sz),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata_b), .valid_o(valid_b), .busy_o(busy_b), .err_o(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: n bytes at a, little-endian; fault if the last byte falls off the end.
  task automatic model(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] r, output logic e);
    int              n;
    longint unsigned last;
    longint unsigned v;
    bit              f;
    n    = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    last = 64'(a) + 64'(n) - 64'd1;
    f    = (last >= 64'(DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
    if (n > 1 && (a % n) != 0) f = 1'b1;
`endif
    r = 32'd0;
    e = f;
    if (!f) begin
      if (w) begin
        for (int k = 0; k < n; k++) mdl[int'(a) + k] = d[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v += 64'(mdl[int'(a) + k]) << (8*k);
        r = 32'(v);
        if (!u && n < 4 && v[8*n-1]) r = r | ~((32'd1 << (8*n)) - 32'd1);
      end
    end
  endtask

  // Caller sits at a negedge (cycle T); returns at the negedge of the valid cycle.
  task automatic acc(input bit sel_b, input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d, input bit junk,
                     output logic [31:0] rd, output logic er);
    int lat;
    lat   = sel_b ? LAT_B : LAT_A;
    we    = w;
    sz    = s;
    uns   = u;
    addr  = a;
    wdata = d;
    if (sel_b) req_b = 1'b1; else req_a = 1'b1;
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      req_a = 1'b0;
      req_b = 1'b0;
      if (junk) begin
        we    = 1'($urandom);
        sz    = 2'($urandom);
        uns   = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        if (sel_b) req_b = 1'b1; else req_a = 1'b1;
      end
      chk("busy_mid", sel_b ? busy_b : busy_a, 32'd1);
      chk("valid_mid", sel_b ? valid_b : valid_a, 32'd0);
    end
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    chk("valid_done", sel_b ? valid_b : valid_a, 32'd1);
    chk("busy_done", sel_b ? busy_b : busy_a, 32'd0);
    rd = sel_b ? rdata_b : rdata_a;
    er = sel_b ? err_b : err_a;
  endtask

  task automatic acc_a(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input bit junk,
                       output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    model(w, s, u, a, d, exp_rd, exp_er);
    acc(1'b0, w, s, u, a, d, junk, rd, er);
    chk("a_rdata", rd, exp_rd);
    chk("a_err", 32'(er), 32'(exp_er));
    last_rd = rd;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] ra;
    rst_a = 1'b0; rst_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; sz = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_valid", valid_a, 32'd0);
    chk("rst_busy", busy_a, 32'd0);
    chk("rst_err", err_a, 32'd0);
    chk("rst_b_valid", valid_b, 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    // Give the whole array known contents, back to back.
    for (int w = 0; w < DEPTH / 4; w++) acc_a(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 1'b0, rd, er);

    // Store then load the same word, load issued in the store's valid cycle.
    acc_a(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, er);
    chk("t1_store_rd", rd, 32'd0);
    acc_a(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, rd, er);
    chk("t1_load", rd, 32'hDEADBEEF);
    chk("t1_err", 32'(er), 32'd0);

    acc_a(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b0, rd, er);
    chk("t2_lb", rd, 32'hFFFFFFDE);
    acc_a(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 1'b0, rd, er);
    chk("t2_lbu", rd, 32'h000000DE);
    acc_a(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 1'b0, rd, er);
    chk("t2_lh", rd, 32'hFFFFBEEF);

    acc_a(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345655, 1'b0, rd, er);
    acc_a(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, rd, er);
    chk("t3_merge", rd, 32'hDEAD55EF);
    repeat (2) @(negedge clk);
    chk("hold_rdata", rdata_a, 32'hDEAD55EF);
    chk("hold_valid", valid_a, 32'd0);
    chk("hold_err", err_a, 32'd0);

    acc_a(1'b1, 2'b10, 1'b0, 32'h3FE, 32'hA5A5A5A5, 1'b0, rd, er);
    chk("t4_st_err", 32'(er), 32'd1);
    acc_a(1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, 1'b0, rd, er);
    chk("t4_ld_ok", 32'(er), 32'd0);
    acc_a(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'd0, 1'b0, rd, er);
    chk("t4_wrap_err", 32'(er), 32'd1);
    chk("t4_wrap_rd", rd, 32'd0);
    @(negedge clk);
    chk("t4_err_drop", err_a, 32'd0);

    // Misaligned word load with req pulses while busy.
    acc_a(1'b0, 2'b10, 1'b0, 32'h12, 32'd0, 1'b1, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("t6_mis_err", 32'(er), 32'd1);
`else
    chk("t6_mis_err", 32'(er), 32'd0);
`endif
    @(negedge clk);
    chk("t6_no_extra", valid_a, 32'd0);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)      ra = $urandom_range(0, DEPTH - 1);
      else if (r < 9) ra = $urandom_range(DEPTH - 8, DEPTH + 7);
      else            ra = $urandom;
      acc_a(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, 1'($urandom), rd, er);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle_valid", valid_a, 32'd0);
        chk("idle_err", err_a, 32'd0);
        chk("idle_rdata", rdata_a, last_rd);
      end
    end

    // LATENCY=3: reset during the in-flight store aborts it.
    acc(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, rd, er);
    chk("b_st_err", 32'(er), 32'd0);
    we = 1'b1; sz = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'hCAFEF00D;
    req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    chk("b_busy", busy_b, 32'd1);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    chk("b_rst_busy", busy_b, 32'd0);
    chk("b_rst_valid", valid_b, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("b_no_valid", valid_b, 32'd0);
    end
    acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1'b0, rd, er);
    chk("b_abort_load", rd, 32'h11223344);
    chk("b_abort_err", 32'(er), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, clocked successor to the pipeline's combinational byte-addressed data memory.
- Sits in the MEM stage. It serves one load/store at a time with a configurable access latency.
- Supports byte, halfword and word sizes, with sign or zero extension on loads.
- Raises a stall (busy_o) to the pipeline while an access is in flight, and flags out-of-range accesses.
- Memory is little-endian: byte at addr holds bits [7:0].

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, >= 4
LATENCY, 2, cycles from request acceptance to valid_o; >= 1
ADDR_W, 32, width of addr_i

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-low reset
req_i  in  1  access request; sampled only while idle
we_i  in  1  1 = store, 0 = load
size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
unsigned_i  in  1  loads: 1 = zero-extend, 0 = sign-extend
addr_i  in  ADDR_W  byte address
wdata_i  in  32  store data; the low bytes are used for byte and halfword stores
rdata_o  out  32  load result, valid while valid_o = 1
valid_o  out  1  one-cycle completion pulse, for loads and stores
busy_o  out  1  access in flight; the pipeline stalls while high
err_o  out  1  with valid_o: access faulted

Behaviour:
- Reset (rst_i = 0 at a clock edge):
  - State goes to IDLE; rdata_o = 0, valid_o = 0, busy_o = 0, err_o = 0.
  - Any in-flight access is aborted: no write occurs and no valid_o is produced.
  - Memory array contents are NOT cleared.
- States:
  - IDLE: if req_i = 1, latch we/size/unsigned/addr/wdata and load cnt = LATENCY-1. Go to WAIT if LATENCY > 1, else go to DONE.
  - WAIT: cnt decrements each cycle; at cnt = 1 go to DONE.
  - DONE is transient, not a held state. On the edge entering it, the access executes and the state returns to IDLE.
- Timing:
  - Request accepted at cycle T.
  - Access executes at the edge ending cycle T+LATENCY-1.
  - valid_o = 1 in cycle T+LATENCY only.
  - busy_o = 1 in cycles T+1 .. T+LATENCY-1. It is never high when LATENCY = 1.
- Back-to-back: in the valid_o cycle the block is IDLE, so a new req_i is accepted there. Throughput is one access per LATENCY cycles.
- req_i while busy_o = 1: ignored; the latched request is unaffected.
- Execute, store:
  - Write the size-selected low bytes of wdata to addr .. addr+n-1, n = 1/2/4.
  - The store is visible to any request accepted in or after the valid_o cycle.
- Execute, load:
  - Read n bytes, assembled little-endian.
  - Byte and halfword loads are extended to 32 bits: zero-extended if unsigned_i = 1, else sign-extended.
- Range fault: if addr+n-1 >= DEPTH_BYTES (compute with no wrap, ADDR_W+1 bits):
  - No write occurs; rdata_o = 0; err_o = 1 with valid_o.
- Outputs hold between accesses:
  - rdata_o holds its last value after valid_o drops.
  - err_o is 0 whenever valid_o = 0.
  - rdata_o = 0 on completion of a store.

Optional Feature:
Macro DMEM_MISALIGN_CHECK_EN.
- Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, is a fault. The fault behaves exactly like a range fault: no write, rdata_o = 0, err_o = 1.
- Undefined: misaligned accesses are legal and use consecutive bytes from addr, as with aligned accesses. Only range faults set err_o.

Test Plan:
1. LATENCY = 2. Store word 0xDEADBEEF at 0x10 (accepted cycle T), then load word at 0x10 in the valid cycle. Required: store valid at T+2 with busy_o = 1 at T+1. Load returns 0xDEADBEEF at T+4 with err_o = 0.
2. After test 1, load byte at 0x13 with unsigned_i = 0 -> 0xFFFFFFDE. Load byte at 0x13 with unsigned_i = 1 -> 0x000000DE. Load halfword at 0x10 with unsigned_i = 0 -> 0xFFFFBEEF.
3. Store byte 0x55 at 0x11 over the test-1 word, then load word at 0x10 -> 0xDEAD55EF. Only byte 0x11 changes.
4. DEPTH_BYTES = 1024: store word at 0x3FE -> err_o = 1 with valid_o, and a subsequent load of word 0x3FC is unchanged. Load at 0xFFFFFFFC -> err_o = 1, rdata_o = 0 (no address wrap).
5. Issue a store at cycle T, drive rst_i = 0 at T+1 with LATENCY = 3, release, then load the same address. Required: no valid_o for the aborted store, and the load returns the pre-store value.
6. Misaligned word load at 0x12:
   - With DMEM_MISALIGN_CHECK_EN defined: err_o = 1, rdata_o = 0.
   - Without it: bytes 0x12..0x15 are returned and err_o = 0.
   - In both builds, req_i pulses while busy_o = 1 produce no extra valid_o.
